// File: rtl/vending_customer.sv
// Customer-side vending FSM: pays PRICE from a latched wallet, waits for soda, tracks change.
// Optional macro VC_CHANGE_CHECK_EN enables the change_err mismatch flag evaluated in DONE.
module vending_customer #(
    parameter int PRICE   = 3,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] n1,
    input  logic [CNT_W-1:0] n2,
    input  logic [CNT_W-1:0] n3,
    input  logic             soda,
    input  logic [1:0]       coin_out,
    output logic [1:0]       coin_in,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [3:0]       change,
    output logic [7:0]       sold_count,
    output logic             change_err
);

    localparam int SW = CNT_W + 3;
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CHECK, ST_SELECT, ST_INSERT, ST_GAP, ST_WAIT, ST_DONE, ST_FAIL
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt1_r;
    logic [CNT_W-1:0] cnt2_r;
    logic [CNT_W-1:0] cnt3_r;
    logic [4:0]       paid_r;
    logic [TW-1:0]    timer_r;
    logic [1:0]       coin_in_r;
    logic [1:0]       coin_s;
    logic [1:0]       pick_s;
    logic             busy_r;
    logic             done_r;
    logic             fail_r;
    logic [3:0]       change_r;
    logic [7:0]       sold_r;
    logic [SW-1:0]    total_s;
    logic [4:0]       due_s;
    logic             accept_s;

    // Largest coin not exceeding what is still due, else the smallest coin that overshoots.
    // The coin code equals its value, so the returned code doubles as the value.
    function automatic logic [1:0] pick_coin(input logic [4:0] due, input logic h1,
                                             input logic h2, input logic h3);
        logic [1:0] c;
        c = 2'b00;
        if (h3 && (due >= 5'd3)) begin
            c = 2'b11;
        end else if (h2 && (due >= 5'd2)) begin
            c = 2'b10;
        end else if (h1 && (due >= 5'd1)) begin
            c = 2'b01;
        end else if (h2) begin
            c = 2'b10;
        end else if (h3) begin
            c = 2'b11;
        end else begin
            c = 2'b00;
        end
        return c;
    endfunction

    // Saturating add of a coin value onto the 4-bit change total.
    function automatic logic [3:0] add_change(input logic [3:0] acc, input logic [1:0] coin);
        logic [4:0] sum;
        sum = {1'b0, acc} + {3'b000, coin};
        return sum[4] ? 4'd15 : sum[3:0];
    endfunction

    // Wallet value, outstanding amount and coin choice for the current decision.
    always_comb begin
        total_s  = SW'(cnt1_r) + (SW'(cnt2_r) << 1) + (SW'(cnt3_r) << 1) + SW'(cnt3_r);
        due_s    = 5'(PRICE) - paid_r;
        pick_s   = pick_coin(due_s, (cnt1_r != '0), (cnt2_r != '0), (cnt3_r != '0));
        accept_s = (state_r == ST_IDLE) && start;
    end

    // Next-state logic and the coin to present during the following cycle.
    always_comb begin
        state_s = state_r;
        coin_s  = 2'b00;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_CHECK;
                else       state_s = ST_IDLE;
            end
            ST_CHECK: begin
                if (total_s < SW'(PRICE)) state_s = ST_FAIL;
                else                      state_s = ST_SELECT;
            end
            ST_SELECT: begin
                // A zero pick cannot follow a passed funds check; treat it as a failure anyway.
                if (pick_s == 2'b00) begin
                    state_s = ST_FAIL;
                end else begin
                    state_s = ST_INSERT;
                    coin_s  = pick_s;
                end
            end
            ST_INSERT: state_s = ST_GAP;
            ST_GAP: begin
                if (paid_r >= 5'(PRICE)) state_s = ST_WAIT;
                else                     state_s = ST_SELECT;
            end
            ST_WAIT: begin
                if (soda)                               state_s = ST_DONE;
                else if (timer_r == TW'(TIMEOUT - 1))   state_s = ST_FAIL;
                else                                    state_s = ST_WAIT;
            end
            ST_DONE: state_s = ST_IDLE;
            ST_FAIL: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and registered status outputs aligned with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            coin_in_r <= 2'b00;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            fail_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            coin_in_r <= coin_s;
            busy_r    <= (state_s != ST_IDLE);
            done_r    <= (state_s == ST_DONE);
            fail_r    <= (state_s == ST_FAIL);
        end
    end

    // Wallet counts, amount paid and WAIT timer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt1_r  <= '0;
            cnt2_r  <= '0;
            cnt3_r  <= '0;
            paid_r  <= 5'd0;
            timer_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        cnt1_r  <= n1;
                        cnt2_r  <= n2;
                        cnt3_r  <= n3;
                        paid_r  <= 5'd0;
                        timer_r <= '0;
                    end
                end
                ST_INSERT: begin
                    paid_r <= paid_r + {3'b000, coin_in_r};
                    case (coin_in_r)
                        2'b01:   cnt1_r <= cnt1_r - {{(CNT_W-1){1'b0}}, 1'b1};
                        2'b10:   cnt2_r <= cnt2_r - {{(CNT_W-1){1'b0}}, 1'b1};
                        2'b11:   cnt3_r <= cnt3_r - {{(CNT_W-1){1'b0}}, 1'b1};
                        default: cnt1_r <= cnt1_r;
                    endcase
                end
                ST_WAIT: timer_r <= timer_r + {{(TW-1){1'b0}}, 1'b1};
                default: timer_r <= timer_r;
            endcase
        end
    end

    // Change accumulation (held through IDLE) and lifetime soda counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            change_r <= 4'd0;
            sold_r   <= 8'd0;
        end else begin
            if (accept_s) begin
                change_r <= 4'd0;
            end else if ((state_r != ST_IDLE) && (coin_out != 2'b00)) begin
                change_r <= add_change(change_r, coin_out);
            end
            if ((state_r == ST_WAIT) && soda && (sold_r != 8'hFF)) begin
                sold_r <= sold_r + 8'd1;
            end
        end
    end

`ifdef VC_CHANGE_CHECK_EN
    logic change_err_r;

    // Flag when the machine's change differs from the overpayment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            change_err_r <= 1'b0;
        end else if (accept_s) begin
            change_err_r <= 1'b0;
        end else if ((state_r == ST_DONE) && ({1'b0, change_r} != (paid_r - 5'(PRICE)))) begin
            change_err_r <= 1'b1;
        end
    end

    assign change_err = change_err_r;
`else
    assign change_err = 1'b0;
`endif

    assign coin_in    = coin_in_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign fail       = fail_r;
    assign change     = change_r;
    assign sold_count = sold_r;

endmodule

// File: tb/tb_vending_customer.sv
// Directed self-checking bench for vending_customer with default parameters.
module tb_vending_customer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] n1, n2, n3;
    logic       soda;
    logic [1:0] coin_out;
    logic [1:0] coin_in;
    logic       busy, done, fail, change_err;
    logic [3:0] change;
    logic [7:0] sold_count;

    int errors = 0;
    int checks = 0;

    vending_customer dut (
        .clk(clk), .reset(reset), .start(start), .n1(n1), .n2(n2), .n3(n3),
        .soda(soda), .coin_out(coin_out), .coin_in(coin_in), .busy(busy),
        .done(done), .fail(fail), .change(change), .sold_count(sold_count),
        .change_err(change_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; n1 = 4'd0; n2 = 4'd0; n3 = 4'd0;
        soda = 1'b0; coin_out = 2'b00;
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_coin", 32'(coin_in), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_change", 32'(change), 32'd0);
        check("rst_sold", 32'(sold_count), 32'd0);
        check("rst_cerr", 32'(change_err), 32'd0);
        #4 reset = 1'b1;
        tick();

        // single value-3 coin, soda in the first WAIT cycle
        n3 = 4'd1; start = 1'b1;
        tick(); start = 1'b0;
        check("t1_check_busy", 32'(busy), 32'd1);
        tick(); check("t1_select_coin", 32'(coin_in), 32'd0);
        tick(); check("t1_insert_coin", 32'(coin_in), 32'd3);
        tick(); check("t1_gap_coin", 32'(coin_in), 32'd0);
        soda = 1'b1;
        tick(); check("t1_wait_done", 32'(done), 32'd0);
        check("t1_wait_busy", 32'(busy), 32'd1);
        tick(); soda = 1'b0;
        check("t1_done", 32'(done), 32'd1);
        check("t1_sold", 32'(sold_count), 32'd1);
        check("t1_change", 32'(change), 32'd0);
        tick();
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);

        // three value-1 coins, each separated by non-coin cycles
        n1 = 4'd3; n3 = 4'd0; start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); check("t2_select", 32'(coin_in), 32'd0);
            tick(); check("t2_insert", 32'(coin_in), 32'd1);
            tick(); check("t2_gap", 32'(coin_in), 32'd0);
        end
        tick();
        check("t2_wait_busy", 32'(busy), 32'd1);
        check("t2_wait_coin", 32'(coin_in), 32'd0);
        soda = 1'b1;
        tick(); soda = 1'b0;
        check("t2_done", 32'(done), 32'd1);
        check("t2_sold", 32'(sold_count), 32'd2);
        tick();

        // two value-2 coins, overpay by 1, machine returns a value-1 coin
        n1 = 4'd0; n2 = 4'd2; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); check("t3_insert_a", 32'(coin_in), 32'd2);
        tick(); check("t3_gap_a", 32'(coin_in), 32'd0);
        tick(); tick(); check("t3_insert_b", 32'(coin_in), 32'd2);
        tick(); check("t3_gap_b", 32'(coin_in), 32'd0);
        tick(); coin_out = 2'b01;
        tick(); coin_out = 2'b00;
        check("t3_change_wait", 32'(change), 32'd1);
        soda = 1'b1;
        tick(); soda = 1'b0;
        check("t3_done", 32'(done), 32'd1);
        check("t3_sold", 32'(sold_count), 32'd3);
        tick();
        check("t3_change_idle", 32'(change), 32'd1);
        check("t3_cerr", 32'(change_err), 32'd0);

        // insufficient funds: fail straight from CHECK
        n1 = 4'd1; n2 = 4'd0; n3 = 4'd0; start = 1'b1;
        tick(); start = 1'b0;
        check("t4_check_busy", 32'(busy), 32'd1);
        check("t4_change_clr", 32'(change), 32'd0);
        tick();
        check("t4_fail", 32'(fail), 32'd1);
        check("t4_coin", 32'(coin_in), 32'd0);
        tick();
        check("t4_fail_pulse", 32'(fail), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_sold", 32'(sold_count), 32'd3);

        // no soda: timeout after 15 WAIT cycles
        n1 = 4'd0; n3 = 4'd1; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < 15; i++) begin
            tick();
            check("t5_wait_fail", 32'(fail), 32'd0);
            check("t5_wait_busy", 32'(busy), 32'd1);
        end
        tick();
        check("t5_fail", 32'(fail), 32'd1);
        tick();
        check("t5_after_busy", 32'(busy), 32'd0);
        check("t5_after_fail", 32'(fail), 32'd0);
        check("t5_sold", 32'(sold_count), 32'd3);

        // start while busy is ignored; soda outside WAIT is ignored
        n3 = 4'd1; start = 1'b1;
        tick(); soda = 1'b1;
        tick(); tick();
        check("t6_insert_coin", 32'(coin_in), 32'd3);
        check("t6_sold_hold", 32'(sold_count), 32'd3);
        soda = 1'b0; start = 1'b0;

        // asynchronous reset during INSERT
        #2 reset = 1'b0;
        #1;
        check("t6_rst_coin", 32'(coin_in), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_sold", 32'(sold_count), 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();
        check("t6_no_done", 32'(done), 32'd0);
        check("t6_no_fail", 32'(fail), 32'd0);
        check("t6_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
